// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: control codes, FSM encoding,
// default widths and the control-code legality helper.
package alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CTL_W_DEF = 4;

    localparam logic [3:0] ALU_CTL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTL_SLT = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic ctl_is_legal(input logic [3:0] ctl);
        logic legal;
        case (ctl)
            ALU_CTL_AND, ALU_CTL_OR, ALU_CTL_ADD,
            ALU_CTL_SUB, ALU_CTL_SLT: legal = 1'b1;
            default:                  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; last_grant resets to 1 so requester 0 wins the
// first contest after reset.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic update,
    output logic grant
);

    logic last_grant_r;

    // Grant selection: sole requester wins, otherwise alternate away from last winner
    always_comb begin
        grant = ~last_grant_r;
        if (valid0 && valid1) begin
            grant = ~last_grant_r;
        end else if (valid0) begin
            grant = 1'b0;
        end else if (valid1) begin
            grant = 1'b1;
        end else begin
            grant = ~last_grant_r;
        end
    end

    // Remember the most recent winner on each accepted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (update) begin
            last_grant_r <= grant;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two valid/ready requesters (round-robin).
// Optional build macro ALU_OPCHK_EN: reject unsupported control codes with resp_err.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CTL_W   = CTL_W_DEF,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [CTL_W-1:0] req0_ctl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [CTL_W-1:0] req1_ctl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [CTL_W-1:0] alu_ctl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,
    output logic             resp_err
);

    localparam int               CNT_W      = 4;
    localparam logic [CNT_W-1:0] LAT_LAST_C = CNT_W'(ALU_LAT - 1);

    state_e           state_r, state_nx_s;
    logic             grant_s, accept_s, illegal_s, lat_done_s;
    logic [WIDTH-1:0] sel_a_s, sel_b_s;
    logic [CTL_W-1:0] sel_ctl_s;
    logic [CNT_W-1:0] lat_cnt_r;
    logic [WIDTH-1:0] alu_a_r, alu_b_r, resp_data_r;
    logic [CTL_W-1:0] alu_ctl_r;
    logic             resp_valid_r, resp_id_r, resp_zero_r;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .update (accept_s),
        .grant  (grant_s)
    );

    // Ready/accept decode and granted-operand select
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if ((state_r == ST_IDLE) && !rst) begin
            req0_ready = !grant_s && req0_valid;
            req1_ready = grant_s && req1_valid;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
        accept_s = req0_ready || req1_ready;
        if (grant_s) begin
            sel_a_s   = req1_a;
            sel_b_s   = req1_b;
            sel_ctl_s = req1_ctl;
        end else begin
            sel_a_s   = req0_a;
            sel_b_s   = req0_b;
            sel_ctl_s = req0_ctl;
        end
        lat_done_s = (lat_cnt_r == LAT_LAST_C);
`ifdef ALU_OPCHK_EN
        illegal_s = !ctl_is_legal(sel_ctl_s[3:0]);
`else
        illegal_s = 1'b0;
`endif
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; illegal codes bypass EXEC entirely
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = illegal_s ? ST_RESP : ST_EXEC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (lat_done_s) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (resp_valid_r && resp_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Operand, latency counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_r      <= '0;
            alu_b_r      <= '0;
            alu_ctl_r    <= '0;
            lat_cnt_r    <= 4'd0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= 1'b0;
            resp_data_r  <= '0;
            resp_zero_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        resp_id_r <= grant_s;
                        lat_cnt_r <= 4'd0;
                        if (illegal_s) begin
                            resp_valid_r <= 1'b1;
                            resp_data_r  <= '0;
                            resp_zero_r  <= 1'b0;
                        end else begin
                            alu_a_r   <= sel_a_s;
                            alu_b_r   <= sel_b_s;
                            alu_ctl_r <= sel_ctl_s;
                        end
                    end
                end
                ST_EXEC: begin
                    if (lat_done_s) begin
                        resp_data_r  <= alu_out;
                        resp_zero_r  <= alu_zero;
                        resp_valid_r <= 1'b1;
                        lat_cnt_r    <= 4'd0;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_OPCHK_EN
    logic resp_err_r;

    // Error flag follows the legality of each accepted control code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_err_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && accept_s) begin
            resp_err_r <= illegal_s;
        end
    end

    assign resp_err = resp_err_r;
`else
    assign resp_err = 1'b0;
`endif

    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_ctl    = alu_ctl_r;
    assign resp_valid = resp_valid_r;
    assign resp_id    = resp_id_r;
    assign resp_data  = resp_data_r;
    assign resp_zero  = resp_zero_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter, with a behavioural ALU
// model standing in for ALUWithControl; a second instance covers ALU_LAT=3.
module tb_alu_share_arbiter;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctl, req1_ctl;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_ctl;
    logic        alu_zero;
    logic        resp_valid, resp_ready, resp_id, resp_zero, resp_err;
    logic [31:0] resp_data;

    logic        l3_valid, l3_ready, l3_r1_ready, l3_rr;
    logic [31:0] l3_alu_a, l3_alu_b, l3_alu_out, l3_data;
    logic [3:0]  l3_alu_ctl;
    logic        l3_alu_zero, l3_rv, l3_id, l3_zero, l3_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [32:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    assign {alu_zero, alu_out}       = alu_model(alu_ctl, alu_a, alu_b);
    assign {l3_alu_zero, l3_alu_out} = alu_model(l3_alu_ctl, l3_alu_a, l3_alu_b);

    alu_share_arbiter #(.WIDTH(32), .CTL_W(4), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctl(req0_ctl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctl(req1_ctl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_out(alu_out), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err)
    );

    alu_share_arbiter #(.WIDTH(32), .CTL_W(4), .ALU_LAT(3)) dut_lat3 (
        .clk(clk), .rst(rst),
        .req0_valid(l3_valid), .req0_ready(l3_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctl(req0_ctl),
        .req1_valid(1'b0), .req1_ready(l3_r1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctl(req1_ctl),
        .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_ctl(l3_alu_ctl), .alu_out(l3_alu_out), .alu_zero(l3_alu_zero),
        .resp_valid(l3_rv), .resp_ready(l3_rr), .resp_id(l3_id),
        .resp_data(l3_data), .resp_zero(l3_zero), .resp_err(l3_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One isolated request from requester sel; latency counted from the ready cycle
    task automatic do_op(input bit sel, input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl,
                         input logic [31:0] exp_data, input bit exp_zero, input int exp_lat,
                         input bit exp_err, input string tag);
        int cnt;
        @(negedge clk);
        resp_ready = 1'b1;
        if (sel) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctl = ctl;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctl = ctl;
        end
        #1;
        chk({tag, "_ready"}, sel ? req1_ready : req0_ready, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!exp_err) begin
            chk({tag, "_alu_ctl"}, alu_ctl, ctl);
            chk({tag, "_alu_a"}, alu_a, a);
        end
        cnt = 1;
        while (!resp_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_latency"}, cnt, exp_lat);
        chk({tag, "_id"}, resp_id, sel);
        chk({tag, "_data"}, resp_data, exp_data);
        chk({tag, "_zero"}, resp_zero, exp_zero);
        chk({tag, "_err"}, resp_err, exp_err);
        @(posedge clk); #1;
        chk({tag, "_done"}, resp_valid, 32'd0);
    endtask

    // Hold the chosen requesters valid and check n responses: ids, data, 3-cycle spacing
    task automatic stream(input bit v0, input bit v1, input int n, input logic [7:0] exp_ids, input string tag);
        int got = 0;
        int cyc = 0;
        int last = -1;
        @(negedge clk);
        resp_ready = 1'b1;
        req0_a = 32'haaaaaaaa; req0_b = 32'h55555555; req0_ctl = 4'b0001;
        req1_a = 32'haaaaaaaa; req1_b = 32'h55555555; req1_ctl = 4'b0111;
        req0_valid = v0;
        req1_valid = v1;
        while (got < n && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (resp_valid) begin
                chk({tag, "_id"}, resp_id, exp_ids[got]);
                chk({tag, "_data"}, resp_data, exp_ids[got] ? 32'h00000001 : 32'hffffffff);
                if (last >= 0) chk({tag, "_spacing"}, cyc - last, 32'd3);
                last = cyc;
                got++;
            end
        end
        chk({tag, "_count"}, got, n);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    typedef struct {
        bit          sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [31:0] exp_data;
        bit          exp_zero;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] hold_data;
    logic [3:0]  prev_ctl;
    int          cnt;

    initial begin
        vecs[0] = '{1'b0, 32'h55555555, 32'haaaaaaaa, 4'b0000, 32'h00000000, 1'b1};
        vecs[1] = '{1'b1, 32'h55555555, 32'haaaaaaaa, 4'b0110, 32'haaaaaaab, 1'b0};
        vecs[2] = '{1'b1, 32'h55555555, 32'haaaaaaaa, 4'b0010, 32'hffffffff, 1'b0};
        vecs[3] = '{1'b0, 32'haaaaaaaa, 32'h55555555, 4'b0001, 32'hffffffff, 1'b0};
        vecs[4] = '{1'b1, 32'haaaaaaaa, 32'h55555555, 4'b0111, 32'h00000001, 1'b0};
        vecs[5] = '{1'b0, 32'h00000005, 32'h00000005, 4'b0110, 32'h00000000, 1'b1};
        vecs[6] = '{1'b0, 32'h00000003, 32'hffffffff, 4'b0111, 32'h00000000, 1'b1};
        vecs[7] = '{1'b1, 32'hffffffff, 32'h00000001, 4'b0010, 32'h00000000, 1'b1};

        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; l3_valid = 1'b0; l3_rr = 1'b1;
        resp_ready = 1'b0;
        req0_a = 32'h0; req0_b = 32'h0; req0_ctl = 4'h0;
        req1_a = 32'h0; req1_b = 32'h0; req1_ctl = 4'h0;
        #12;
        chk("rst_req0_ready", req0_ready, 32'd0);
        chk("rst_req1_ready", req1_ready, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_ctl", alu_ctl, 32'd0);
        chk("rst_resp", {resp_valid, resp_id, resp_zero, resp_err}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].ctl, vecs[i].exp_data,
                  vecs[i].exp_zero, LAT + 1, 1'b0, $sformatf("vec%0d", i));
        end

        // Contention right after a fresh reset: req0 first, then strict alternation
        @(negedge clk); rst = 1'b1; #2; rst = 1'b0;
        stream(1'b1, 1'b1, 6, 8'b0010_1010, "contend");
        stream(1'b1, 1'b0, 3, 8'b0000_0000, "solo0");

        // Backpressure: result held stable while both requesters wait
        @(negedge clk);
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctl = 4'b0010;
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_ctl = 4'b0010;
        cnt = 0;
        while (!resp_valid && cnt < 10) begin
            @(posedge clk); #1; cnt++;
        end
        chk("bp_valid_seen", resp_valid, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_hold", resp_valid, 32'd1);
            chk("bp_data_hold", resp_data, 32'd3);
            chk("bp_id_hold", resp_id, 32'd0);
            chk("bp_ready_low", {req0_ready, req1_ready}, 32'd0);
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released", resp_valid, 32'd0);
        chk("bp_next_grant", {req0_ready, req1_ready}, 32'b01);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(posedge clk);

        // Reset while the operation is in EXEC discards it entirely
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'h12345678; req0_b = 32'h1; req0_ctl = 4'b0010;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chk("rexec_loaded", alu_a, 32'h12345678);
        rst = 1'b1; #1;
        chk("rexec_alu_a", alu_a, 32'd0);
        chk("rexec_alu_ctl", alu_ctl, 32'd0);
        chk("rexec_valid", resp_valid, 32'd0);
        @(negedge clk); rst = 1'b0;
        hold_data = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            hold_data = hold_data | {31'd0, resp_valid};
        end
        chk("rexec_no_resp", hold_data, 32'd0);
        stream(1'b1, 1'b1, 2, 8'b0000_0010, "rexec_rr");

        prev_ctl = alu_ctl;
`ifdef ALU_OPCHK_EN
        do_op(1'b0, 32'd1, 32'd2, 4'b1111, 32'd0, 1'b0, 1, 1'b1, "opchk");
        chk("opchk_alu_ctl_kept", alu_ctl, prev_ctl);
        do_op(1'b1, 32'd4, 32'd1, 4'b0110, 32'd3, 1'b0, LAT + 1, 1'b0, "opchk_legal");
`else
        do_op(1'b0, 32'd1, 32'd2, 4'b1111, 32'd0, 1'b1, LAT + 1, 1'b0, "noopchk");
        chk("noopchk_ctl_changed", {31'd0, alu_ctl != prev_ctl}, 32'd1);
`endif

        // Longer ALU latency on the second instance
        @(negedge clk);
        req0_a = 32'd7; req0_b = 32'd5; req0_ctl = 4'b0110; l3_valid = 1'b1;
        #1;
        chk("lat3_ready", l3_ready, 32'd1);
        @(posedge clk); #1;
        l3_valid = 1'b0;
        cnt = 1;
        while (!l3_rv && cnt < 20) begin
            @(posedge clk); #1; cnt++;
        end
        chk("lat3_latency", cnt, 32'd4);
        chk("lat3_data", l3_data, 32'd2);
        chk("lat3_zero", l3_zero, 32'd0);
        @(posedge clk); #1;
        chk("lat3_done", l3_rv, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
